vc_rr_credit_arbiter: RTL
=========================

// Module: vc_rr_credit_arbiter
// PURPOSE
//  Shares one valid/credit (VC) link among N_REQ valid/ready (VR) requesters.
//  Round-robin grant, gated by a local credit counter mirroring free slots in the
//  downstream vc_vr_converter buffer. Sits on the sender side of the link and
//  drives the converter's s_data_i/s_valid_i, consuming its s_credit_o.
// PARAMETERS
//  DATA_WIDTH  8  flit width
//  CREDIT_NUM  2  max credits; equals the receiver's buffer depth
//  N_REQ       4  number of requesters, >=2
// PORTS
//  clk            in   1                 clock
//  rst_n          in   1                 async active-low reset
//  s_data_i       in   N_REQ*DATA_WIDTH  requester data, req i at [i*DATA_WIDTH +: DATA_WIDTH]
//  s_valid_i      in   N_REQ             requester valid
//  s_ready_o      out  N_REQ             requester ready (one-hot or zero)
//  m_data_o       out  DATA_WIDTH        VC link data
//  m_valid_o      out  1                 VC link valid; each high cycle is one flit
//  m_credit_i     in   1                 one-cycle credit-return pulse from the receiver
//  m_src_o        out  SRC_W             index of the requester that sourced m_data_o
//  credit_err_o   out  1                 sticky: credit returned while the counter was full
// BEHAVIOUR
//  Reset: m_valid_o=0, m_data_o=0, m_src_o=0, credit_err_o=0, credit_cnt=0, rr_ptr=0.
//   The counter starts empty; the receiver grants the initial CREDIT_NUM credits
//   via m_credit_i pulses after reset.
//  credit_cnt: width CNT_W=$clog2(CREDIT_NUM+1).
//   - send only: -1. credit only: +1. Both in the same cycle: unchanged.
//   - credit while cnt==CREDIT_NUM and no send: hold at CREDIT_NUM, set credit_err_o.
//     credit_err_o clears only on reset.
//  Grant (combinational from registered state):
//   - can_send = (credit_cnt != 0). A credit arriving this cycle is not usable until the next cycle.
//   - If can_send, grant the first asserted s_valid_i searching rr_ptr, rr_ptr+1, ... with
//     wrap mod N_REQ. s_ready_o = grant; otherwise s_ready_o = 0.
//   - s_ready_o never depends on the requester's own s_valid_i beyond arbitration.
//   - A requester holds data and valid until it sees ready (VR rule).
//  Transfer on s_valid_i[g] & s_ready_o[g]:
//   - Next edge: m_valid_o=1, m_data_o=data[g], m_src_o=g, rr_ptr=(g+1)%N_REQ, cnt-1.
//   - Latency is 1 cycle. Back-to-back flits are allowed, 1/cycle while credits last.
//   - No transfer: m_valid_o=0, m_data_o and m_src_o hold their previous values, rr_ptr holds.
//  Fairness: with all requesters valid and credits never exhausted, the grant order is
//   0,1,..,N_REQ-1,0,...
//  Reset mid-transfer: all state returns to reset values immediately, with no flit emitted.
//   The receiver is reset together with this block.
//  Invariant (asserted): credit_cnt <= CREDIT_NUM; $onehot0(s_ready_o).
// STRUCTURE
//  vc_pkg: function src_w(N) = (N>1 ? $clog2(N) : 1), function cnt_w(C) = $clog2(C+1).
//   SRC_W and CNT_W are derived from these.
//  Sub-module rr_arbiter #(N): inputs req[N], ptr[SRC_W], en; outputs gnt[N] and gnt_idx.
//   Purely combinational. The top holds rr_ptr, credit_cnt, the output registers and the error flag.
// TESTING (DATA_WIDTH=8, CREDIT_NUM=2, N_REQ=4)
//  1. After reset, all s_valid_i=1 with no credits -> s_ready_o=0, m_valid_o=0 for 10 cycles.
//  2. Two credit pulses; req0=0x11, req2=0x33 valid -> m_data_o 0x11 (src 0), then 0x33 (src 2)
//     on consecutive cycles; s_ready_o=0 afterwards; credit_cnt=0.
//  3. All 4 valid (data 0xA0..0xA3), m_credit_i pulsed each cycle after 2 initial credits
//     -> src order 0,1,2,3,0, with no bubbles.
//  4. credit_cnt=1, send and m_credit_i in the same cycle -> cnt stays 1;
//     next cycle the send proceeds.
//  5. 3 credit pulses without sends -> cnt=2, credit_err_o=1 and stays 1 until rst_n.
//  6. rst_n low while m_valid_o=1 -> m_valid_o=0, m_src_o=0, cnt=0 asynchronously;
//     the first grant after re-credit goes to req0.

Source files
------------

// File: rtl/vc_pkg.sv
// Shared width helpers and the credit-event encoding for the VC round-robin
// credit arbiter.
package vc_pkg;

  function automatic int src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int c);
    return $clog2(c + 1);
  endfunction

  // {send, credit_return} observed in one cycle
  typedef enum logic [1:0] {
    CR_IDLE   = 2'b00,
    CR_RETURN = 2'b01,
    CR_SEND   = 2'b10,
    CR_BOTH   = 2'b11
  } credit_ev_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request found
// when searching from ptr upward with wrap-around; no grant when en is low.
module rr_arbiter
  import vc_pkg::*;
#(
  parameter int N     = 4,
  parameter int SRC_W = src_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SRC_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     gnt,
  output logic [SRC_W-1:0] gnt_idx
);

  always_comb begin : arb_search
    logic             found;
    logic [SRC_W-1:0] idx;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    // NOTE: blocking assignments here are deliberate; found must update
    // within the loop so later iterations see an earlier hit.
    for (int k = 0; k < N; k++) begin
      idx = SRC_W'((int'(ptr) + k) % N);
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/vc_rr_credit_arbiter.sv
// Shares one valid/credit link among N_REQ valid/ready requesters using a
// round-robin grant gated by a local mirror of the receiver's free slots.
module vc_rr_credit_arbiter
  import vc_pkg::*;
#(
  parameter int  DATA_WIDTH = 8,
  parameter int  CREDIT_NUM = 2,
  parameter int  N_REQ      = 4,
  localparam int SRC_W      = src_w(N_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ*DATA_WIDTH-1:0]   s_data_i,
  input  logic [N_REQ-1:0]              s_valid_i,
  output logic [N_REQ-1:0]              s_ready_o,
  output logic [DATA_WIDTH-1:0]         m_data_o,
  output logic                          m_valid_o,
  input  logic                          m_credit_i,
  output logic [SRC_W-1:0]              m_src_o,
  output logic                          credit_err_o
);

  localparam int               CNT_W   = cnt_w(CREDIT_NUM);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CREDIT_NUM);

  logic [CNT_W-1:0]      r_credit_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [SRC_W-1:0]      r_rr_ptr;
  logic [SRC_W-1:0]      w_ptr_nxt;
  logic [SRC_W-1:0]      w_gnt_idx;
  logic [N_REQ-1:0]      w_gnt;
  logic                  w_can_send;
  logic                  w_send;
  logic                  w_err_set;
  logic [DATA_WIDTH-1:0] w_gnt_data;
  credit_ev_e            w_ev;

  logic                  r_m_valid;
  logic [DATA_WIDTH-1:0] r_m_data;
  logic [SRC_W-1:0]      r_m_src;
  logic                  r_credit_err;

  // A credit returned this cycle only becomes usable next cycle.
  assign w_can_send = (r_credit_cnt != '0);

  rr_arbiter #(
    .N     (N_REQ),
    .SRC_W (SRC_W)
  ) u_arb (
    .req     (s_valid_i),
    .ptr     (r_rr_ptr),
    .en      (w_can_send),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  assign w_send     = |w_gnt;
  assign s_ready_o  = w_gnt;
  assign w_gnt_data = s_data_i[int'(w_gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign w_ptr_nxt  = (w_gnt_idx == SRC_W'(N_REQ - 1)) ? '0 : w_gnt_idx + SRC_W'(1);
  assign w_ev       = credit_ev_e'({w_send, m_credit_i});

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    w_cnt_nxt = r_credit_cnt;
    w_err_set = 1'b0;
    case (w_ev)
      CR_SEND:   w_cnt_nxt = r_credit_cnt - CNT_W'(1);
      CR_RETURN: begin
        if (r_credit_cnt == CNT_MAX) w_err_set = 1'b1;
        else                         w_cnt_nxt = r_credit_cnt + CNT_W'(1);
      end
      default:   w_cnt_nxt = r_credit_cnt;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_credit_cnt <= '0;
      r_rr_ptr     <= '0;
      r_m_valid    <= 1'b0;
      // NOTE: the link data/source registers are reset too, so the link
      // never shows X before the first flit.
      r_m_data     <= '0;
      r_m_src      <= '0;
      r_credit_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling
      // pre-edge values regardless of statement order.
      r_credit_cnt <= w_cnt_nxt;
      r_m_valid    <= w_send;
      if (w_send) begin
        r_m_data <= w_gnt_data;
        r_m_src  <= w_gnt_idx;
        r_rr_ptr <= w_ptr_nxt;
      end
      if (w_err_set) r_credit_err <= 1'b1;
    end
  end

  assign m_valid_o    = r_m_valid;
  assign m_data_o     = r_m_data;
  assign m_src_o      = r_m_src;
  assign credit_err_o = r_credit_err;

  a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n)
    r_credit_cnt <= CNT_MAX);
  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(s_ready_o));

endmodule
